// File: rtl/axi_m_pkg.sv
// axi_m_pkg: FSM states, AXI response codes and helpers shared by axi_burst_master.
// Also supplies the AXI_define.svh width macros when that header is not already in scope.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_SIZE_WORD
`define AXI_SIZE_WORD 3'b010
`endif
`ifndef AXI_BURST_INC
`define AXI_BURST_INC 2'b01
`endif

package axi_m_pkg;

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Response codes are ordered by severity, so the worst one is simply the larger code.
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: the five AXI4 channels between a burst master and the interconnect.
interface axi_burst_master_if;

   logic [`AXI_ID_BITS-1:0]   AWID_M;
   logic [`AXI_ADDR_BITS-1:0] AWADDR_M;
   logic [`AXI_LEN_BITS-1:0]  AWLEN_M;
   logic [`AXI_SIZE_BITS-1:0] AWSIZE_M;
   logic [1:0]                AWBURST_M;
   logic                      AWVALID_M;
   logic                      AWREADY_M;

   logic [`AXI_DATA_BITS-1:0] WDATA_M;
   logic [`AXI_STRB_BITS-1:0] WSTRB_M;
   logic                      WLAST_M;
   logic                      WVALID_M;
   logic                      WREADY_M;

   logic [`AXI_ID_BITS-1:0]   BID_M;
   logic [1:0]                BRESP_M;
   logic                      BVALID_M;
   logic                      BREADY_M;

   logic [`AXI_ID_BITS-1:0]   ARID_M;
   logic [`AXI_ADDR_BITS-1:0] ARADDR_M;
   logic [`AXI_LEN_BITS-1:0]  ARLEN_M;
   logic [`AXI_SIZE_BITS-1:0] ARSIZE_M;
   logic [1:0]                ARBURST_M;
   logic                      ARVALID_M;
   logic                      ARREADY_M;

   logic [`AXI_ID_BITS-1:0]   RID_M;
   logic [`AXI_DATA_BITS-1:0] RDATA_M;
   logic [1:0]                RRESP_M;
   logic                      RLAST_M;
   logic                      RVALID_M;
   logic                      RREADY_M;

   modport master (
      output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M, input AWREADY_M,
      output WDATA_M, WSTRB_M, WLAST_M, WVALID_M, input WREADY_M,
      input  BID_M, BRESP_M, BVALID_M, output BREADY_M,
      output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, input ARREADY_M,
      input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, output RREADY_M
   );

   modport slave (
      input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M, output AWREADY_M,
      input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M, output WREADY_M,
      output BID_M, BRESP_M, BVALID_M, input BREADY_M,
      input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, output ARREADY_M,
      output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, input RREADY_M
   );

endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR word-burst master (1-4 beats) fed by a command/stream port.
// Build macro AXI_M_WSTRB_EN adds a wr_strb input that is forwarded to WSTRB_M.
module axi_burst_master
   import axi_m_pkg::*;
#(
   parameter logic [`AXI_ID_BITS-1:0]  MID     = 4'd0,
   parameter logic [`AXI_LEN_BITS-1:0] MAX_LEN = 4'd3
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [`AXI_ADDR_BITS-1:0] req_addr,
   input  logic [`AXI_LEN_BITS-1:0]  req_len,
   input  logic [`AXI_DATA_BITS-1:0] wr_data,
`ifdef AXI_M_WSTRB_EN
   input  logic [`AXI_STRB_BITS-1:0] wr_strb,
`endif
   input  logic                      wr_valid,
   output logic                      wr_ready,
   output logic [`AXI_DATA_BITS-1:0] rd_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic                      rd_last,
   output logic                      done,
   output logic [1:0]                done_resp,
   axi_burst_master_if.master        axi
);

   typedef logic [`AXI_ADDR_BITS-1:0] addr_t;
   typedef logic [`AXI_LEN_BITS-1:0]  len_t;

   state_t     state_q, state_d;
   addr_t      addr_q, addr_d;
   len_t       len_q, len_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] resp_q, resp_d;
   logic       done_q, done_d;
   logic [1:0] done_resp_q, done_resp_d;
   logic       beatIsLast;
   logic       wHandshake;
   logic       rHandshake;
   logic       unusedRid;

   assign beatIsLast = (len_t'(cnt_q) == len_q);
   assign wHandshake = (state_q == W) && wr_valid && axi.WREADY_M;
   assign rHandshake = (state_q == R) && axi.RVALID_M && rd_ready;
   assign unusedRid  = ^axi.RID_M;

   // Holding off req_ready during the done pulse makes the next accept land the cycle after done.
   assign req_ready = (state_q == IDLE) && !done_q;
   assign done      = done_q;
   assign done_resp = done_resp_q;

   assign axi.AWID_M    = MID;
   assign axi.AWADDR_M  = addr_q;
   assign axi.AWLEN_M   = len_q;
   assign axi.AWSIZE_M  = `AXI_SIZE_WORD;
   assign axi.AWBURST_M = `AXI_BURST_INC;
   assign axi.AWVALID_M = (state_q == AW);

   assign axi.WDATA_M  = (state_q == W) ? wr_data : '0;
`ifdef AXI_M_WSTRB_EN
   assign axi.WSTRB_M  = wr_strb;
`else
   assign axi.WSTRB_M  = 4'hF;
`endif
   assign axi.WLAST_M  = (state_q == W) && beatIsLast;
   assign axi.WVALID_M = (state_q == W) && wr_valid;
   assign wr_ready     = (state_q == W) && axi.WREADY_M;

   assign axi.BREADY_M = (state_q == B);

   assign axi.ARID_M    = MID;
   assign axi.ARADDR_M  = addr_q;
   assign axi.ARLEN_M   = len_q;
   assign axi.ARSIZE_M  = `AXI_SIZE_WORD;
   assign axi.ARBURST_M = `AXI_BURST_INC;
   assign axi.ARVALID_M = (state_q == AR);

   assign axi.RREADY_M = (state_q == R) && rd_ready;
   assign rd_valid     = (state_q == R) && axi.RVALID_M;
   assign rd_data      = (state_q == R) ? axi.RDATA_M : '0;
   assign rd_last      = (state_q == R) && axi.RLAST_M;

   // Burst sequencing: one command in flight, address phase, data beats, then completion.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      done_d      = 1'b0;
      done_resp_d = done_resp_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr & ~addr_t'(3);
               len_d   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
               cnt_d   = 2'd0;
               resp_d  = RESP_OKAY;
               state_d = req_write ? AW : AR;
            end
         end
         AW: if (axi.AWREADY_M) state_d = W;
         W: begin
            if (wHandshake) begin
               cnt_d = cnt_q + 2'd1;
               if (beatIsLast) state_d = B;
            end
         end
         B: begin
            if (axi.BVALID_M) begin
               done_d      = 1'b1;
               done_resp_d = (axi.BID_M != MID) ? RESP_SLVERR : axi.BRESP_M;
               state_d     = IDLE;
            end
         end
         AR: if (axi.ARREADY_M) state_d = R;
         R: begin
            if (rHandshake) begin
               cnt_d  = cnt_q + 2'd1;
               resp_d = resp_max(resp_q, axi.RRESP_M);
               // A last flag that disagrees with the requested length marks the burst as a slave error.
               if (axi.RLAST_M != beatIsLast) resp_d = RESP_SLVERR;
               if (axi.RLAST_M) begin
                  done_d      = 1'b1;
                  done_resp_d = resp_d;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= 2'd0;
         resp_q      <= RESP_OKAY;
         done_q      <= 1'b0;
         done_resp_q <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         resp_q      <= resp_d;
         done_q      <= done_d;
         done_resp_q <= done_resp_d;
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed and randomized bursts against a transaction-level model of axi_burst_master.
// The bench plays the AXI slave and the upstream user from a single initial block.
module tb_axi_burst_master;
   import axi_m_pkg::*;

   localparam logic [3:0] MID = 4'd0;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [31:0] wr_data;
`ifdef AXI_M_WSTRB_EN
   logic [3:0]  wr_strb;
`endif
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        rd_last;
   logic        done;
   logic [1:0]  done_resp;

   int errors = 0;
   int checks = 0;

   axi_burst_master_if axi ();

   axi_burst_master #(.MID(MID), .MAX_LEN(4'd3)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data),
`ifdef AXI_M_WSTRB_EN
      .wr_strb(wr_strb),
`endif
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
      .done(done), .done_resp(done_resp),
      .axi(axi)
   );

   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one command in the idle cycle and returns at the first cycle after acceptance.
   task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [3:0] len);
      req_valid = 1'b1;
      req_write = write;
      req_addr  = addr;
      req_len   = len;
      #1 checkOutput("req_ready_idle", req_ready, 1);
      @(negedge ACLK);
      req_valid = 1'b0;
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [3:0] len, input int awWait, input int maxWait,
                          input logic [1:0] bresp, input logic [3:0] bid, input bit checkLat);
      int          nBeats;
      int          cyc;
      logic [3:0]  expLen;
      logic [1:0]  expResp;
      logic [31:0] data;
      logic [3:0]  expStrb;
      expLen  = (len > 4'd3) ? 4'd3 : len;
      nBeats  = int'(expLen) + 1;
      expResp = (bid != MID) ? 2'b10 : bresp;
      applyStimulus(1'b1, addr, len);
      cyc = 1;
      for (int k = 0; k <= awWait; k++) begin
         axi.AWREADY_M = (k == awWait);
         #1;
         checkOutput("awvalid", axi.AWVALID_M, 1);
         checkOutput("awaddr", axi.AWADDR_M, addr & 32'hFFFF_FFFC);
         checkOutput("awlen", axi.AWLEN_M, expLen);
         checkOutput("arvalid_in_write", axi.ARVALID_M, 0);
         checkOutput("req_ready_busy", req_ready, 0);
         @(negedge ACLK);
         cyc++;
      end
      axi.AWREADY_M = 1'b0;
      for (int b = 0; b < nBeats; b++) begin
         repeat ($urandom_range(0, maxWait)) begin
            wr_valid = 1'b0;
            axi.WREADY_M = 1'($urandom_range(0, 1));
            #1 checkOutput("wvalid_idle", axi.WVALID_M, 0);
            @(negedge ACLK);
            cyc++;
         end
         data = $urandom;
         wr_data = data;
         wr_valid = 1'b1;
`ifdef AXI_M_WSTRB_EN
         expStrb = (b == 0) ? 4'b0110 : 4'($urandom);
         wr_strb = expStrb;
`else
         expStrb = 4'hF;
`endif
         repeat ($urandom_range(0, maxWait)) begin
            axi.WREADY_M = 1'b0;
            #1 checkOutput("wr_ready_stall", wr_ready, 0);
            checkOutput("wvalid_stall", axi.WVALID_M, 1);
            @(negedge ACLK);
            cyc++;
         end
         axi.WREADY_M = 1'b1;
         #1;
         checkOutput("wvalid", axi.WVALID_M, 1);
         checkOutput("wr_ready", wr_ready, 1);
         checkOutput("wdata", axi.WDATA_M, data);
         checkOutput("wstrb", axi.WSTRB_M, expStrb);
         checkOutput("wlast", axi.WLAST_M, (b == nBeats - 1));
         @(negedge ACLK);
         cyc++;
      end
      wr_valid = 1'b0;
      axi.WREADY_M = 1'b0;
      repeat ($urandom_range(0, maxWait)) begin
         #1 checkOutput("bready_wait", axi.BREADY_M, 1);
         checkOutput("done_early", done, 0);
         @(negedge ACLK);
         cyc++;
      end
      axi.BVALID_M = 1'b1;
      axi.BRESP_M  = bresp;
      axi.BID_M    = bid;
      #1 checkOutput("bready", axi.BREADY_M, 1);
      @(negedge ACLK);
      cyc++;
      axi.BVALID_M = 1'b0;
      #1;
      checkOutput("write_done", done, 1);
      checkOutput("write_done_resp", done_resp, expResp);
      checkOutput("req_ready_during_done", req_ready, 0);
      if (checkLat) checkOutput("write_latency", cyc, int'(expLen) + 4);
      @(negedge ACLK);
      #1;
      checkOutput("write_done_pulse", done, 0);
      checkOutput("req_ready_after_write", req_ready, 1);
   endtask

   task automatic doRead(input logic [31:0] addr, input logic [3:0] len, input int arWait, input int idleCycles,
                         input int stallCycles, input logic [7:0] respVec, input int lastBeat, input bit checkLat);
      int          cyc;
      logic [3:0]  expLen;
      logic [1:0]  expResp;
      logic [1:0]  beatResp;
      logic [31:0] data;
      expLen  = (len > 4'd3) ? 4'd3 : len;
      expResp = 2'b00;
      for (int b = 0; b <= lastBeat; b++) begin
         beatResp = respVec[2*b +: 2];
         if (beatResp > expResp) expResp = beatResp;
      end
      if (lastBeat != int'(expLen)) expResp = 2'b10;
      applyStimulus(1'b0, addr, len);
      cyc = 1;
      for (int k = 0; k <= arWait; k++) begin
         axi.ARREADY_M = (k == arWait);
         #1;
         checkOutput("arvalid", axi.ARVALID_M, 1);
         checkOutput("araddr", axi.ARADDR_M, addr & 32'hFFFF_FFFC);
         checkOutput("arlen", axi.ARLEN_M, expLen);
         checkOutput("awvalid_in_read", axi.AWVALID_M, 0);
         checkOutput("req_ready_busy", req_ready, 0);
         @(negedge ACLK);
         cyc++;
      end
      axi.ARREADY_M = 1'b0;
      for (int b = 0; b <= lastBeat; b++) begin
         repeat (idleCycles) begin
            axi.RVALID_M = 1'b0;
            rd_ready = 1'($urandom_range(0, 1));
            #1 checkOutput("rd_valid_idle", rd_valid, 0);
            @(negedge ACLK);
            cyc++;
         end
         data = $urandom;
         axi.RVALID_M = 1'b1;
         axi.RDATA_M  = data;
         axi.RLAST_M  = (b == lastBeat);
         axi.RRESP_M  = respVec[2*b +: 2];
         axi.RID_M    = MID;
         repeat (stallCycles) begin
            rd_ready = 1'b0;
            #1 checkOutput("rready_stall", axi.RREADY_M, 0);
            checkOutput("rd_valid_stall", rd_valid, 1);
            @(negedge ACLK);
            cyc++;
         end
         rd_ready = 1'b1;
         #1;
         checkOutput("rd_valid", rd_valid, 1);
         checkOutput("rready", axi.RREADY_M, 1);
         checkOutput("rd_data", rd_data, data);
         checkOutput("rd_last", rd_last, (b == lastBeat));
         checkOutput("done_mid_read", done, 0);
         @(negedge ACLK);
         cyc++;
      end
      axi.RVALID_M = 1'b0;
      axi.RLAST_M  = 1'b0;
      rd_ready = 1'b0;
      #1;
      checkOutput("read_done", done, 1);
      checkOutput("read_done_resp", done_resp, expResp);
      checkOutput("req_ready_during_done", req_ready, 0);
      if (checkLat) checkOutput("read_latency", cyc, int'(expLen) + 3);
      @(negedge ACLK);
      #1;
      checkOutput("read_done_pulse", done, 0);
      checkOutput("req_ready_after_read", req_ready, 1);
   endtask

   initial begin
      logic [31:0] rAddr;
      logic [3:0]  rLen;
      logic [3:0]  rLenC;
      ARESET = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
`ifdef AXI_M_WSTRB_EN
      wr_strb = 4'hF;
`endif
      axi.AWREADY_M = 1'b0; axi.WREADY_M = 1'b0; axi.ARREADY_M = 1'b0;
      axi.BVALID_M = 1'b0; axi.BRESP_M = 2'b00; axi.BID_M = MID;
      axi.RVALID_M = 1'b0; axi.RDATA_M = '0; axi.RRESP_M = 2'b00; axi.RLAST_M = 1'b0; axi.RID_M = MID;
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_awvalid", axi.AWVALID_M, 0);
      checkOutput("rst_arvalid", axi.ARVALID_M, 0);
      checkOutput("rst_wvalid", axi.WVALID_M, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_done_resp", done_resp, 0);
      checkOutput("rst_awaddr", axi.AWADDR_M, 0);
      checkOutput("rst_awlen", axi.AWLEN_M, 0);
      checkOutput("rst_awsize", axi.AWSIZE_M, 3'b010);
      checkOutput("rst_awburst", axi.AWBURST_M, 2'b01);
      checkOutput("rst_arsize", axi.ARSIZE_M, 3'b010);
      checkOutput("rst_arburst", axi.ARBURST_M, 2'b01);
      @(negedge ACLK);

      $display("[TB] directed bursts");
      doWrite(32'h0000_0104, 4'd3, 0, 0, RESP_OKAY, MID, 1'b1);
      doRead(32'h0000_0203, 4'd1, 0, 2, 1, 8'h00, 1, 1'b0);
      doRead(32'h0000_0300, 4'd2, 0, 0, 0, 8'h0C, 2, 1'b1);
      doRead(32'h0000_0400, 4'd3, 0, 0, 0, 8'h00, 1, 1'b0);
      doWrite(32'h0000_0500, 4'd2, 5, 0, RESP_OKAY, MID, 1'b0);
      doWrite(32'h0000_0600, 4'd1, 0, 1, RESP_OKAY, 4'h5, 1'b0);
      doWrite(32'h0000_0702, 4'd9, 0, 0, RESP_DECERR, MID, 1'b1);
      doRead(32'h0000_0800, 4'd0, 0, 0, 0, 8'h02, 0, 1'b1);

      axi.RVALID_M = 1'b1; axi.BVALID_M = 1'b1; rd_ready = 1'b1;
      #1;
      checkOutput("idle_rready", axi.RREADY_M, 0);
      checkOutput("idle_bready", axi.BREADY_M, 0);
      checkOutput("idle_rd_valid", rd_valid, 0);
      @(negedge ACLK);
      axi.RVALID_M = 1'b0; axi.BVALID_M = 1'b0; rd_ready = 1'b0;
      #1;
      checkOutput("idle_no_done", done, 0);
      checkOutput("idle_req_ready", req_ready, 1);

      $display("[TB] reset during write data phase");
      applyStimulus(1'b1, 32'h0000_0040, 4'd3);
      axi.AWREADY_M = 1'b1;
      @(negedge ACLK);
      axi.AWREADY_M = 1'b0;
      wr_valid = 1'b1; wr_data = $urandom; axi.WREADY_M = 1'b1;
      @(negedge ACLK);
      axi.WREADY_M = 1'b0;
      rd_ready = 1'b1;
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      checkOutput("midrst_wvalid", axi.WVALID_M, 0);
      checkOutput("midrst_awvalid", axi.AWVALID_M, 0);
      checkOutput("midrst_arvalid", axi.ARVALID_M, 0);
      checkOutput("midrst_bready", axi.BREADY_M, 0);
      checkOutput("midrst_rready", axi.RREADY_M, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_req_ready", req_ready, 1);
      wr_valid = 1'b0; rd_ready = 1'b0;
      @(negedge ACLK);
      #1 checkOutput("midrst_no_done", done, 0);
      doRead(32'h0000_0900, 4'd2, 1, 0, 0, 8'h00, 2, 1'b0);

      $display("[TB] randomized bursts");
      for (int t = 0; t < 12; t++) begin
         rAddr = $urandom;
         rLen  = 4'($urandom_range(0, 5));
         rLenC = (rLen > 4'd3) ? 4'd3 : rLen;
         if ($urandom_range(0, 1) == 1)
            doWrite(rAddr, rLen, $urandom_range(0, 2), 2, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 4'h9 : MID, 1'b0);
         else
            doRead(rAddr, rLen, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   8'($urandom), int'(rLenC), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
